pht_update_scheduler: RTL

Write-side controller for the pattern history table (PHT) of 2-bit saturating counters.
- Sequences a post-reset clear sweep of the table.
- Arbitrates the single PHT write port between back-end repair updates and front-end direct (speculative) updates.
- Buffers direct updates in a small FIFO.
- Discards wrong-path direct updates whenever a repair arrives.
- Sits between the branch status check stage / IF predictor and the PHT storage array.

---
 rtl/pht_update_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pht_update_scheduler.sv
// Write-side controller for the 2-bit-counter PHT: clear sweep, repair/direct arbitration, direct-update FIFO.
// Optional statistics counters are enabled by defining PHT_SCHED_STAT_EN.
module pht_update_scheduler #(
    parameter int         PHT_IDX_W = 10,
    parameter int         DQ_DEPTH  = 4,
    parameter logic [1:0] INIT_CTR  = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done_o,
    input  logic                 repair_valid_i,
    input  logic [PHT_IDX_W-1:0] repair_idx_i,
    input  logic [1:0]           repair_ctr_i,
    input  logic                 repair_take_i,
    input  logic                 direct_valid_i,
    output logic                 direct_ready_o,
    input  logic [PHT_IDX_W-1:0] direct_idx_i,
    input  logic [1:0]           direct_ctr_i,
    input  logic                 direct_take_i,
    output logic                 pht_we_o,
    output logic [PHT_IDX_W-1:0] pht_waddr_o,
    output logic [1:0]           pht_wdata_o,
    output logic                 busy_o
`ifdef PHT_SCHED_STAT_EN
   ,output logic [31:0]          repair_cnt_o,
    output logic [31:0]          flush_drop_cnt_o
`endif
);

    localparam int AW = $clog2(DQ_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_e;

    // FIFO entries carry the already-updated counter value, so a pop is a plain write.
    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic [1:0]           ctr;
    } entry_t;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    state_e               state_q, state_d;
    logic [PHT_IDX_W:0]   ptr_q, ptr_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 we_q, we_d;
    logic [PHT_IDX_W-1:0] waddr_q, waddr_d;
    logic [1:0]           wdata_q, wdata_d;
    entry_t               mem_q [DQ_DEPTH];
    entry_t               head;
    logic                 fifo_empty, fifo_full, repair_acc, pop, enq;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign direct_ready_o = (state_q == S_RUN) && !fifo_full;
    assign init_done_o    = (state_q == S_RUN);
    assign busy_o         = (state_q == S_INIT) || !fifo_empty;
    assign repair_acc     = (state_q == S_RUN) && repair_valid_i;
    assign pop            = (state_q == S_RUN) && !repair_valid_i && !fifo_empty;
    assign enq            = direct_valid_i && direct_ready_o && !repair_valid_i;

    assign pht_we_o    = we_q;
    assign pht_waddr_o = waddr_q;
    assign pht_wdata_o = wdata_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_INIT: begin
                // The extra pointer bit marks the sweep as complete; RUN starts on the following edge.
                if (!ptr_q[PHT_IDX_W]) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[PHT_IDX_W-1:0];
                    wdata_d = INIT_CTR;
                    ptr_d   = ptr_q + 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (repair_acc) begin
                    we_d     = 1'b1;
                    waddr_d  = repair_idx_i;
                    wdata_d  = sat(repair_ctr_i, repair_take_i);
                    rd_ptr_d = wr_ptr_q;
                end else if (pop) begin
                    we_d     = 1'b1;
                    waddr_d  = head.idx;
                    wdata_d  = head.ctr;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and active-low here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_INIT;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q[AW-1:0]] <= '{idx: direct_idx_i, ctr: sat(direct_ctr_i, direct_take_i)};
    end

`ifdef PHT_SCHED_STAT_EN
    logic [31:0] repair_cnt_q, flush_drop_cnt_q;
    logic [AW:0] occupancy;

    assign occupancy        = wr_ptr_q - rd_ptr_q;
    assign repair_cnt_o     = repair_cnt_q;
    assign flush_drop_cnt_o = flush_drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            repair_cnt_q     <= '0;
            flush_drop_cnt_q <= '0;
        end else if (repair_acc) begin
            repair_cnt_q     <= repair_cnt_q + 32'd1;
            flush_drop_cnt_q <= flush_drop_cnt_q + 32'(occupancy)
                                + 32'(direct_valid_i && direct_ready_o);
        end
    end
`endif

endmodule
